// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARMv8 fetch stage.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of {pc, pc+4, instr, valid}.
// Holds when neither load nor bubble is asserted; bubble only clears valid.
module fetch_if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [XLEN-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc       <= '0;
      if_pc_plus4 <= PC_STEP;
      if_instr    <= '0;
      if_valid    <= 1'b0;
    end else if (load) begin
      if_pc       <= pc;
      if_pc_plus4 <= pc + PC_STEP;
      if_instr    <= instr;
      if_valid    <= 1'b1;
    end else if (bubble) begin
      // Payload is left stale on purpose; downstream qualifies it with valid.
      if_valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC select, BOOT/RUN/HALT/FAULT control and fetch counter.
// One-cycle fetch latency; stall holds PC and IF/ID, taken branch overrides stall with a bubble.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_br_taken,
  input  logic [XLEN-1:0]    i_br_target,
  input  logic               i_halt,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [XLEN-1:0]    o_imem_addr,
  output logic [XLEN-1:0]    o_if_pc,
  output logic [XLEN-1:0]    o_if_pc_plus4,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic               o_if_valid,
  output logic               o_fault,
  output logic [CNT_W-1:0]   o_fetch_cnt
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            load;
  logic            bubble;

  // Priority in RUN: halt, then any taken branch, then stall, then sequential fetch.
  always_comb begin
    load   = 1'b0;
    bubble = 1'b0;
    case (state)
      RUN: begin
        if (i_halt || i_br_taken) bubble = 1'b1;
        else if (!i_stall)        load   = 1'b1;
      end
      default: bubble = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      o_fault     <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (i_halt) begin
            state <= HALT;
          end else if (i_br_taken) begin
            if (!is_word_aligned(i_br_target)) begin
              state   <= FAULT;
              o_fault <= 1'b1;
            end else begin
              pc <= i_br_target;
            end
          end else if (!i_stall) begin
            pc          <= pc + PC_STEP;
            o_fetch_cnt <= o_fetch_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_imem_addr = pc;

  fetch_if_id_reg u_if_id (
    .clk         (i_clk),
    .rst         (i_rst),
    .load        (load),
    .bubble      (bubble),
    .pc          (pc),
    .instr       (i_instr),
    .if_pc       (o_if_pc),
    .if_pc_plus4 (o_if_pc_plus4),
    .if_instr    (o_if_instr),
    .if_valid    (o_if_valid)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random traffic,
// expected observations from a behavioural model, compared at every falling edge.
module tb_fetch_pc_unit;

  localparam int          CW  = 4;
  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b1;
  logic        rst, stall, br, halt;
  logic [63:0] tgt;
  logic [31:0] instr;
  logic [63:0] imem_addr, if_pc, if_pc4;
  logic [31:0] if_instr;
  logic        if_valid, fault;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hAA00_0000 + a[31:0];
  endfunction

  assign instr = mem_word(imem_addr);

  fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_br_taken    (br),
    .i_br_target   (tgt),
    .i_halt        (halt),
    .i_instr       (instr),
    .o_imem_addr   (imem_addr),
    .o_if_pc       (if_pc),
    .o_if_pc_plus4 (if_pc4),
    .o_if_instr    (if_instr),
    .o_if_valid    (if_valid),
    .o_fault       (fault),
    .o_fetch_cnt   (cnt)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] if_pc;
    logic [63:0] if_pc4;
    logic [31:0] if_instr;
    logic        valid;
    logic        fault;
    logic [63:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   done     = 0;

  // Behavioural model: what the stage should look like after each clock edge.
  bit          m_boot, m_stopped, m_valid, m_fault;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinstr;
  longint      m_captures;

  task automatic m_reset();
    m_boot = 1; m_stopped = 0; m_valid = 0; m_fault = 0;
    m_pc = RPC; m_ifpc = 0; m_ifinstr = 0; m_captures = 0;
  endtask

  task automatic m_edge();
    if (rst) m_reset();
    else if (m_boot) begin m_boot = 0; m_valid = 0; end
    else if (m_stopped) m_valid = 0;
    else if (halt) begin m_stopped = 1; m_valid = 0; end
    else if (br && (tgt % 4) != 0) begin m_stopped = 1; m_fault = 1; m_valid = 0; end
    else if (br) begin m_pc = tgt; m_valid = 0; end
    else if (!stall) begin
      m_ifpc     = m_pc;
      m_ifinstr  = mem_word(m_pc);
      m_valid    = 1;
      m_pc       = m_pc + 64'd4;
      m_captures = m_captures + 1;
    end
  endtask

  task automatic push_obs();
    obs_t o;
    o.addr     = m_pc;
    o.if_pc    = m_ifpc;
    o.if_pc4   = m_ifpc + 64'd4;
    o.if_instr = m_ifinstr;
    o.valid    = m_valid;
    o.fault    = m_fault;
    o.cnt      = 64'(m_captures % (64'd1 << CW));
    exp_q.push_back(o);
  endtask

  // Inputs change just after the rising edge; a newly asserted reset acts at once.
  task automatic cycle(input bit r, input bit s, input bit b, input logic [63:0] t, input bit h);
    @(posedge clk);
    #1;
    m_edge();
    rst = r; stall = s; br = b; tgt = t; halt = h;
    if (r) m_reset();
    push_obs();
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, want);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow cyc=%0d got=0 expected=1", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr",   imem_addr,       e.addr);
          chk("if_valid",    64'(if_valid),   64'(e.valid));
          chk("fault",       64'(fault),      64'(e.fault));
          chk("fetch_cnt",   64'(cnt),        e.cnt);
          if (e.valid || !if_valid) begin
            chk("if_pc",     if_pc,           e.if_pc);
            chk("if_pc_plus4", if_pc4,        e.if_pc4);
            chk("if_instr",  64'(if_instr),   64'(e.if_instr));
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit          r, s, b, h;
    logic [63:0] t;
    rst = 1; stall = 0; br = 0; tgt = 0; halt = 0;
    m_reset();
    push_obs();

    // Reset, boot, sequential fetch from RESET_PC.
    cycle(1, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    // Stall holds everything for three edges.
    repeat (3) cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    // Taken branch together with stall: branch wins.
    cycle(0, 1, 1, 64'h2000, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    // Wrap through the top of the address space, then halt at PC 0.
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    repeat (10) cycle(0, 1'($urandom), 1'($urandom), 64'h4000, 1'($urandom));
    // Mid-operation reset, then a misaligned redirect and ignored follow-ups.
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 64'h2002, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 64'h3000, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0, 0);

    // Random traffic.
    repeat (800) begin
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 12);
      h = ($urandom_range(0, 99) < 2);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 90) t[1:0] = 2'b00;
      cycle(r, s, b, t, h);
    end
    cycle(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    done = 1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
